bln_vector_checker: RTL and testbench
=====================================

// Module: bln_vector_checker
// PURPOSE
//   Upstream stimulus and downstream checker for the Boolean-equation circuit (A,B,C,D -> x,y).
//   Walks all 16 input vectors, holds each for a settle window, samples x/y, compares against a
//   golden model, and reports mismatch count plus the first failing vector.
//   Sits beside the circuit in self-checking test/demo tops; the DUT remains purely combinational.
// PARAMETERS
//   SETTLE_CYC  2                         cycles each vector is held before sampling (>=1)
//   CNT_W       $clog2(SETTLE_CYC+1)      settle-counter width (derived; do not override)
// PORTS
//   clk               in   1  single clock; all state updates on posedge
//   rst_n             in   1  reset, synchronous, active-low
//   start             in   1  1-cycle pulse; begins a sweep from IDLE or DONE
//   A,B,C,D           out  1  registered vector to DUT; vec index bit3..0 = A,B,C,D
//   x_in,y_in         in   1  DUT outputs, sampled only in SAMPLE state
//   busy              out  1  high from the cycle after start until DONE is entered
//   done              out  1  high in DONE; held until next start or reset
//   pass              out  1  valid when done: 1 iff err_count==0
//   err_count         out  5  mismatching vectors this sweep (0..16)
//   first_fail_vec    out  4  {A,B,C,D} of the first mismatch
//   first_fail_valid  out  1  at least one mismatch recorded
// BEHAVIOUR
//   Reset (rst_n==0 at posedge): state=IDLE; every output 0; idx=0; settle count=0.
//   Golden model: x_exp = A | C;  y_exp = (~B & C) | (B & ~C & ~D).
//   FSM IDLE -> APPLY -> SAMPLE -> (APPLY | DONE):
//     IDLE:   start=1 -> idx=0, clear err_count/first_fail_*, drive vec(0), busy=1, go APPLY.
//     APPLY:  hold vector; count SETTLE_CYC cycles, then go SAMPLE.
//     SAMPLE: mismatch if x_in!=x_exp or y_in!=y_exp (one error per vector even if both differ).
//             On mismatch: err_count+1; if !first_fail_valid, capture vector, set first_fail_valid.
//             If idx==15: go DONE, busy=0, done=1, pass=(final err_count==0).
//             Otherwise: idx+1, drive next vector, go APPLY.
//     DONE:   outputs frozen; vector output held at the last value; start -> same as IDLE start
//             (done/pass drop next cycle).
//   Latency: start to done = 16*(SETTLE_CYC+1) + 1 cycles.
//   start while busy is ignored; no effect on idx or counters.
//   rst_n low mid-sweep: abandon sweep next edge; all outputs 0; no partial results kept.
//   err_count cannot exceed 16 (5 bits); no wrap.
//   idx is 4-bit; the 15->0 increment is never taken (DONE is entered instead).
// CONFIGURATION
//   BLN_GRAY_ORDER_EN defined:   driven vector = idx ^ (idx>>1) (Gray order; one input toggles
//                                per step); golden and first_fail_vec use the driven vector.
//   BLN_GRAY_ORDER_EN undefined: driven vector = idx (binary 0000..1111).
// STRUCTURE
//   Package bln_pkg:
//     - state enum {IDLE, APPLY, SAMPLE, DONE}
//     - localparam NUM_VEC=16
//     - function bln_golden(vec) returning {x_exp, y_exp}
//   Sub-module bln_golden_model: combinational golden equations, also reusable by other benches.
//   Top: FSM, idx counter, settle counter, error/capture registers.
// TESTING
//   1. Correct DUT, SETTLE_CYC=2, one start -> done at cycle 49; pass=1; err_count=0; first_fail_valid=0.
//   2. x_in tied 0, binary order -> err_count=12; first_fail_vec=4'b0010; pass=0.
//   3. Same as 2 with BLN_GRAY_ORDER_EN -> err_count=12; first_fail_vec=4'b0011.
//   4. y_in = ~y_exp -> err_count=16; first_fail_vec=4'b0000.
//   5. rst_n low for 1 cycle at idx=7 -> all outputs 0 next edge; new start gives a full, clean sweep.
//   6. start pulsed at idx=3 while busy -> ignored; done still at cycle 49; then start from DONE -> counters cleared, sweep repeats.

Source files
------------

// File: rtl/bln_pkg.sv
// Shared types and the reference equations for the A,B,C,D -> x,y Boolean circuit.
package bln_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC = 16;

    // Returns {x_exp, y_exp}; vec bit3..0 map to A,B,C,D.
    function automatic logic [1:0] bln_golden(input logic [3:0] vec);
        logic a, b, c, d;
        {a, b, c, d} = vec;
        return {a | c, (~b & c) | (b & ~c & ~d)};
    endfunction

endpackage

// File: rtl/bln_golden_model.sv
// Combinational reference for the Boolean circuit; usable standalone by other benches.
module bln_golden_model
    import bln_pkg::*;
(
    input  logic [3:0] vec_i,
    output logic       x_exp_o,
    output logic       y_exp_o
);

    assign {x_exp_o, y_exp_o} = bln_golden(vec_i);

endmodule

// File: rtl/bln_vector_checker.sv
// Sweeps all 16 input vectors into the Boolean circuit and checks x/y against the golden model.
// Define BLN_GRAY_ORDER_EN to walk the vectors in Gray-code order instead of binary.
module bln_vector_checker
    import bln_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = $clog2(SETTLE_CYC + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    input  logic       x_in,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    function automatic logic [3:0] drive_vec(input logic [3:0] i);
`ifdef BLN_GRAY_ORDER_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [4:0]       err_q, err_d;
    logic [3:0]       ffvec_q, ffvec_d;
    logic             ffv_q, ffv_d;

    logic             x_exp, y_exp;
    logic             mismatch;

    bln_golden_model u_golden (
        .vec_i   (vec_q),
        .x_exp_o (x_exp),
        .y_exp_o (y_exp)
    );

    // Both outputs wrong still counts as a single failing vector.
    assign mismatch = (x_in != x_exp) || (y_in != y_exp);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffvec_d = ffvec_q;
        ffv_d   = ffv_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = APPLY;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    vec_d   = drive_vec(4'd0);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 5'd0;
                    ffvec_d = 4'd0;
                    ffv_d   = 1'b0;
                end
            end
            APPLY: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                // Last vector ends the sweep; idx never wraps back to 0.
                if (idx_q == 4'(NUM_VEC - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    idx_d   = idx_q + 4'd1;
                    vec_d   = drive_vec(idx_q + 4'd1);
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            ffvec_q <= 4'd0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffvec_q <= ffvec_d;
            ffv_q   <= ffv_d;
        end
    end

    assign {A, B, C, D}     = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_bln_vector_checker.sv
// Directed bench for bln_vector_checker with a behavioural Boolean circuit and selectable faults.
module tb_bln_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       A, B, C, D;
    logic       x_in, y_in;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec;
    logic       first_fail_valid;

    // 0: correct circuit, 1: x stuck at 0, 2: y inverted, 3: x and y inverted
    int mode = 0;
    int n_chk = 0;
    int n_fail = 0;

    logic x_good, y_good;

    always #5 clk = ~clk;

    assign x_good = A | C;
    assign y_good = (~B & C) | (B & ~C & ~D);

    always_comb begin
        x_in = x_good;
        y_in = y_good;
        case (mode)
            1: x_in = 1'b0;
            2: y_in = ~y_good;
            3: begin x_in = ~x_good; y_in = ~y_good; end
            default: ;
        endcase
    end

    bln_vector_checker #(.SETTLE_CYC(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .A                (A),
        .B                (B),
        .C                (C),
        .D                (D),
        .x_in             (x_in),
        .y_in             (y_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

`ifdef BLN_GRAY_ORDER_EN
    localparam logic [3:0] EXP_FF_XSTUCK = 4'b0011;
    localparam logic [3:0] EXP_LAST_VEC  = 4'b1000;
    localparam logic [3:0] VEC_AT_IDX7   = 4'b0100;
    localparam logic [3:0] VEC_AT_IDX3   = 4'b0010;
`else
    localparam logic [3:0] EXP_FF_XSTUCK = 4'b0010;
    localparam logic [3:0] EXP_LAST_VEC  = 4'b1111;
    localparam logic [3:0] VEC_AT_IDX7   = 4'b0111;
    localparam logic [3:0] VEC_AT_IDX3   = 4'b0011;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] all_outs();
        return {A, B, C, D, busy, done, pass, err_count, first_fail_vec, first_fail_valid};
    endfunction

    // Pulses start (called just after a posedge) and waits for done; optionally re-pulses
    // start once while busy when the driven vector equals pulse_vec.
    task automatic sweep(input string tag, input int pulse_vec, output int cyc);
        bit pulsed = 1'b0;
        start = 1'b1;
        cyc   = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (cyc == 1) begin
                chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
                chk({tag, "_cleared_after_start"},
                    {22'd0, done, pass, err_count, first_fail_valid, A, B, C, D}, 32'd0);
            end
            if (done) break;
            if (pulse_vec >= 0 && !pulsed && {A, B, C, D} == pulse_vec[3:0]) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        chk({tag, "_latency"}, cyc, 32'd49);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_last_vec_held"}, {28'd0, A, B, C, D}, {28'd0, EXP_LAST_VEC});
    endtask

    initial begin
        int cyc;
        int guard;

        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {15'd0, all_outs()}, 32'd0);
        rst_n = 1'b1;

        // Correct circuit
        mode = 0;
        sweep("good", -1, cyc);
        chk("good_pass", {31'd0, pass}, 32'd1);
        chk("good_err", {27'd0, err_count}, 32'd0);
        chk("good_ffv", {31'd0, first_fail_valid}, 32'd0);

        // Done is held while idle in DONE
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", {30'd0, done, pass}, 32'd3);

        // x stuck at 0
        mode = 1;
        sweep("xstuck", -1, cyc);
        chk("xstuck_err", {27'd0, err_count}, 32'd12);
        chk("xstuck_ffvec", {28'd0, first_fail_vec}, {28'd0, EXP_FF_XSTUCK});
        chk("xstuck_ffv", {31'd0, first_fail_valid}, 32'd1);
        chk("xstuck_pass", {31'd0, pass}, 32'd0);

        // y inverted: every vector fails
        mode = 2;
        sweep("yinv", -1, cyc);
        chk("yinv_err", {27'd0, err_count}, 32'd16);
        chk("yinv_ffvec", {28'd0, first_fail_vec}, 32'd0);
        chk("yinv_pass", {31'd0, pass}, 32'd0);

        // Both outputs wrong still counts one error per vector
        mode = 3;
        sweep("both", -1, cyc);
        chk("both_err", {27'd0, err_count}, 32'd16);
        chk("both_ffvec", {28'd0, first_fail_vec}, 32'd0);

        // Reset mid-sweep at idx 7 with errors already accumulated
        mode = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while ({A, B, C, D} != VEC_AT_IDX7 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("reach_idx7", {31'd0, guard < 100}, 32'd1);
        chk("midsweep_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midsweep_reset_outputs", {15'd0, all_outs()}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", {15'd0, all_outs()}, 32'd0);
        mode = 0;
        sweep("post_reset", -1, cyc);
        chk("post_reset_pass", {31'd0, pass}, 32'd1);
        chk("post_reset_err", {27'd0, err_count}, 32'd0);

        // Start while busy is ignored
        mode = 1;
        sweep("busy_start", VEC_AT_IDX3, cyc);
        chk("busy_start_err", {27'd0, err_count}, 32'd12);
        chk("busy_start_ffvec", {28'd0, first_fail_vec}, {28'd0, EXP_FF_XSTUCK});

        // Restart from DONE clears results and repeats the sweep
        mode = 0;
        sweep("restart", -1, cyc);
        chk("restart_pass", {31'd0, pass}, 32'd1);
        chk("restart_err", {27'd0, err_count}, 32'd0);
        chk("restart_ffv", {31'd0, first_fail_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
